// File: rtl/seven_seg_pkg.sv
// Shared seven-segment constants: active-low {a,b,c,d,e,f,g} patterns and segment bit positions.
package seven_seg_pkg;

  localparam int SEG_W = 7;

  localparam int SEG_A = 6;
  localparam int SEG_B = 5;
  localparam int SEG_C = 4;
  localparam int SEG_D = 3;
  localparam int SEG_E = 2;
  localparam int SEG_F = 1;
  localparam int SEG_G = 0;

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

  // Packed table, element k is the pattern for hex value k (listed F down to 0).
  localparam logic [15:0][SEG_W-1:0] SEG_HEX = {
    7'h38, 7'h30, 7'h42, 7'h31,   // F E d C
    7'h60, 7'h08, 7'h04, 7'h00,   // b A 9 8
    7'h0F, 7'h20, 7'h24, 7'h4C,   // 7 6 5 4
    7'h06, 7'h12, 7'h4F, 7'h01    // 3 2 1 0
  };

endpackage

// File: rtl/seven_seg_hex_lut.sv
// Combinational hex nibble to active-low seven-segment pattern decoder.
module seven_seg_hex_lut
  import seven_seg_pkg::*;
(
  input  logic [3:0]       hex,
  output logic [SEG_W-1:0] seg
);

  assign seg = SEG_HEX[hex];

endmodule

// File: rtl/seven_seg_scan_driver.sv
// N-digit multiplexed common-anode seven-segment driver with coherent shadow load,
// per-digit blank/decimal point and optional left-rotate scrolling.
module seven_seg_scan_driver
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int CLK_DIV       = 50000,
  parameter int SCROLL_FRAMES = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic                    load,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    scroll_en,
  output logic [SEG_W-1:0]        seg_out,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   an_out
);

  localparam int PRE_W = $clog2(CLK_DIV);
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int FRM_W = $clog2(SCROLL_FRAMES + 1);
  localparam int DIG_W = 4 * NUM_DIGITS;

  logic [PRE_W-1:0]      prescale_p0;
  logic [IDX_W-1:0]      scan_idx_p0;
  logic [FRM_W-1:0]      frame_cnt;
  logic [DIG_W-1:0]      digits_sh;
  logic [NUM_DIGITS-1:0] blank_sh;
  logic [NUM_DIGITS-1:0] dp_sh;

  logic                  tick;
  logic                  frame_end;
  logic                  frame_last;
  logic                  scroll_step;
  logic [3:0]            nibble_sel;
  logic [SEG_W-1:0]      hex_seg;
  logic [NUM_DIGITS-1:0] an_sel;

  assign tick        = (prescale_p0 == PRE_W'(CLK_DIV - 1));
  assign frame_end   = tick && (scan_idx_p0 == IDX_W'(NUM_DIGITS - 1));
  assign frame_last  = (frame_cnt == FRM_W'(SCROLL_FRAMES - 1));
  assign scroll_step = frame_end && scroll_en && frame_last;

  // ---- stage p0: prescaler and scan position ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescale_p0 <= '0;
      scan_idx_p0 <= '0;
    end else begin
      prescale_p0 <= tick ? '0 : prescale_p0 + 1'b1;
      if (tick) begin
        scan_idx_p0 <= (scan_idx_p0 == IDX_W'(NUM_DIGITS - 1)) ? '0 : scan_idx_p0 + 1'b1;
      end
    end
  end

  // Frame counter also wraps to 0 on a load/step collision, so the next rotate is a full period away.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt <= '0;
    end else if (!scroll_en) begin
      frame_cnt <= '0;
    end else if (frame_end) begin
      frame_cnt <= frame_last ? '0 : frame_cnt + 1'b1;
    end
  end

  // A load always beats a coincident scroll step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digits_sh <= '0;
      blank_sh  <= '0;
      dp_sh     <= '0;
    end else if (load) begin
      digits_sh <= digits_in;
      blank_sh  <= blank_in;
      dp_sh     <= dp_in;
    end else if (scroll_step) begin
      digits_sh <= {digits_sh[DIG_W-5:0], digits_sh[DIG_W-1:DIG_W-4]};
      blank_sh  <= {blank_sh[NUM_DIGITS-2:0], blank_sh[NUM_DIGITS-1]};
      dp_sh     <= {dp_sh[NUM_DIGITS-2:0], dp_sh[NUM_DIGITS-1]};
    end
  end

  assign nibble_sel = digits_sh[{scan_idx_p0, 2'b00} +: 4];
  assign an_sel     = ~(NUM_DIGITS'(1) << scan_idx_p0);

  seven_seg_hex_lut u_hex_lut (
    .hex (nibble_sel),
    .seg (hex_seg)
  );

  // ---- stage p1: registered pins, anode and segments switch on the same edge ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_out <= SEG_BLANK;
      dp_out  <= 1'b1;
      an_out  <= '1;
    end else if (blank_sh[scan_idx_p0]) begin
      seg_out <= SEG_BLANK;
      dp_out  <= 1'b1;
      an_out  <= '1;
    end else begin
      seg_out <= hex_seg;
      dp_out  <= ~dp_sh[scan_idx_p0];
      an_out  <= an_sel;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Scoreboard bench: stimulus side predicts each cycle's pins from a time-based display model,
// a separate monitor compares the registered outputs one edge later.
module tb_seven_seg_scan_driver;

  localparam int N  = 4;
  localparam int CD = 4;
  localparam int SF = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] digits_in = '0;
  logic        load = 1'b0;
  logic [3:0]  blank_in = '0;
  logic [3:0]  dp_in = '0;
  logic        scroll_en = 1'b0;
  logic [6:0]  seg_out;
  logic        dp_out;
  logic [3:0]  an_out;

  seven_seg_scan_driver #(
    .NUM_DIGITS    (N),
    .CLK_DIV       (CD),
    .SCROLL_FRAMES (SF)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .digits_in (digits_in),
    .load      (load),
    .blank_in  (blank_in),
    .dp_in     (dp_in),
    .scroll_en (scroll_en),
    .seg_out   (seg_out),
    .dp_out    (dp_out),
    .an_out    (an_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
  } disp_t;

  localparam disp_t DARK = {7'h7F, 1'b1, 4'hF};

  disp_t exp_q[$];
  int    checks = 0;
  int    passed = 0;

  // Display model: content per digit, edges since reset, frames seen while scrolling.
  int m_dig[N];
  bit m_blank[N];
  bit m_dp[N];
  int m_edges;
  int m_frames;

  function automatic logic [6:0] ref_hex(input int v);
    case (v)
      0:  return 7'b0000001;
      1:  return 7'b1001111;
      2:  return 7'b0010010;
      3:  return 7'b0000110;
      4:  return 7'b1001100;
      5:  return 7'b0100100;
      6:  return 7'b0100000;
      7:  return 7'b0001111;
      8:  return 7'b0000000;
      9:  return 7'b0000100;
      10: return 7'b0001000;
      11: return 7'b1100000;
      12: return 7'b0110001;
      13: return 7'b1000010;
      14: return 7'b0110000;
      default: return 7'b0111000;
    endcase
  endfunction

  task automatic check(input string name, input disp_t act, input disp_t exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s @%0t: got seg=%b dp=%b an=%b, expected seg=%b dp=%b an=%b",
                  name, $time, act.seg, act.dp, act.an, exp.seg, exp.dp, exp.an);
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_dig[i] = 0; m_blank[i] = 0; m_dp[i] = 0;
    end
    m_edges  = 0;
    m_frames = 0;
  endtask

  // Pins after the next edge show the digit that was being scanned before that edge.
  function automatic disp_t model_view();
    int    idx;
    disp_t d;
    idx = (m_edges / CD) % N;
    if (m_blank[idx]) return DARK;
    d.seg = ref_hex(m_dig[idx]);
    d.dp  = !m_dp[idx];
    d.an  = 4'hF;
    d.an[idx] = 1'b0;
    return d;
  endfunction

  function automatic bit next_is_step();
    return !rst && scroll_en && ((m_edges + 1) % (N * CD) == 0) && (m_frames == SF - 1);
  endfunction

  task automatic model_edge();
    bit step;
    int tmp_d[N];
    bit tmp_b[N];
    bit tmp_p[N];
    step = 0;
    m_edges++;
    if (!scroll_en) m_frames = 0;
    else if (m_edges % (N * CD) == 0) begin
      m_frames++;
      if (m_frames == SF) begin
        m_frames = 0;
        step = 1;
      end
    end
    if (load) begin
      for (int i = 0; i < N; i++) begin
        m_dig[i]   = int'(digits_in[4*i +: 4]);
        m_blank[i] = blank_in[i];
        m_dp[i]    = dp_in[i];
      end
    end else if (step) begin
      for (int i = 0; i < N; i++) begin
        tmp_d[(i + 1) % N] = m_dig[i];
        tmp_b[(i + 1) % N] = m_blank[i];
        tmp_p[(i + 1) % N] = m_dp[i];
      end
      m_dig = tmp_d; m_blank = tmp_b; m_dp = tmp_p;
    end
  endtask

  // Called at a falling edge with inputs already set: predict the next edge's pins.
  task automatic step();
    if (rst) begin
      exp_q.push_back(DARK);
      model_reset();
    end else begin
      exp_q.push_back(model_view());
      model_edge();
    end
    @(negedge clk);
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic pulse_load(input logic [15:0] d, input logic [3:0] b, input logic [3:0] p);
    digits_in = d; blank_in = b; dp_in = p; load = 1'b1;
    step();
    load = 1'b0;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    #1;
    check("async_reset", {seg_out, dp_out, an_out}, DARK);
    repeat (n) step();
    rst = 1'b0;
  endtask

  // Monitor: every rising edge the DUT presents new registered pins.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) check("scan_pins", {seg_out, dp_out, an_out}, exp_q.pop_front());
    end
  end

  initial begin
    bit hit;
    model_reset();
    @(negedge clk);
    check("reset_state", {seg_out, dp_out, an_out}, DARK);
    run(2);
    rst = 1'b0;

    pulse_load(16'h1234, 4'h0, 4'h0);
    run(40);

    digits_in = 16'($urandom);
    blank_in  = 4'($urandom);
    run(20);

    pulse_load(16'h1234, 4'b1000, 4'b0010);
    run(40);

    run(5);
    pulse_load(16'hFEA8, 4'h0, 4'h0);
    run(20);

    do_reset(3);
    run(10);

    scroll_en = 1'b1;
    pulse_load(16'h1234, 4'h0, 4'h0);
    run(N * CD * 5);
    scroll_en = 1'b0;
    run(N * CD * 3);

    scroll_en = 1'b1;
    hit = 0;
    for (int i = 0; i < 200 && !hit; i++) begin
      if (next_is_step()) begin
        hit = 1;
        pulse_load(16'($urandom), 4'h0, 4'($urandom));
      end else begin
        step();
      end
    end
    checks++;
    if (hit) passed++;
    else $display("FAIL collision_search: step cycle not reached within 200 cycles");
    run(N * CD * 5);

    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 99) == 0) scroll_en = ~scroll_en;
      if ($urandom_range(0, 399) == 0) begin
        do_reset($urandom_range(1, 3));
      end else if ($urandom_range(0, 15) == 0 || (next_is_step() && $urandom_range(0, 1) == 0)) begin
        pulse_load(16'($urandom), 4'($urandom_range(0, 3) == 0 ? $urandom : 0), 4'($urandom));
      end else begin
        digits_in = 16'($urandom);
        step();
      end
    end

    @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() == 0) passed++;
    else $display("FAIL drain: %0d expectations left, required 0", exp_q.size());

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
